rpn_stack_alu: RTL

Parametrised successor to the team's stack calculator. It holds a LIFO operand stack of configurable width and depth and executes push, pop, unary, binary-arithmetic and stack-manipulation opcodes. It adds full/overflow detection, an occupancy count, error codes, and a multicycle iterative divider with a busy handshake. It sits behind a command source that drives op/in/apply each clock.

---
 rtl/rpn_stack_alu.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rpn_stack_alu.sv
`default_nettype none
// ============================================================================
// Module   : rpn_stack_alu
// Purpose  : RPN stack calculator. Holds a LIFO operand stack of W-bit
//            entries, D deep, and executes push/pop, unary, binary arithmetic
//            and stack-manipulation opcodes. DIV/MOD run on a multicycle
//            restoring divider (one quotient bit per clock) behind busy.
// Ports    : clk, rst (sync, active-high)
//            in[W-1:0]  push operand       op[3:0]   opcode
//            apply      execute op         head      top of stack (0 if empty)
//            size       entry count        empty/full occupancy flags
//            busy       divide in flight   valid/err last accepted op status
// Revision : 1.0 - initial release
// ============================================================================
module rpn_stack_alu #(
    parameter int W  = 8,
    parameter int D  = 16,
    localparam int SZ = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in,
    input  logic [3:0]    op,
    input  logic          apply,
    output logic [W-1:0]  head,
    output logic [SZ-1:0] size,
    output logic          empty,
    output logic          full,
    output logic          busy,
    output logic          valid,
    output logic [1:0]    err
);

    localparam int c_aw = (D > 1) ? $clog2(D) : 1;
    localparam int c_cw = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(W - 1);

    localparam logic [3:0] c_op_push  = 4'd0;
    localparam logic [3:0] c_op_pop   = 4'd1;
    localparam logic [3:0] c_op_inc   = 4'd2;
    localparam logic [3:0] c_op_dec   = 4'd3;
    localparam logic [3:0] c_op_add   = 4'd4;
    localparam logic [3:0] c_op_sub   = 4'd5;
    localparam logic [3:0] c_op_mul   = 4'd6;
    localparam logic [3:0] c_op_div   = 4'd7;
    localparam logic [3:0] c_op_mod   = 4'd8;
    localparam logic [3:0] c_op_dup   = 4'd9;
    localparam logic [3:0] c_op_swap  = 4'd10;
    localparam logic [3:0] c_op_clear = 4'd11;

    logic [W-1:0]    r_stk [D];
    logic [SZ-1:0]   r_size;
    logic [1:0]      r_err;
    logic            r_busy;
    logic            r_mod;
    logic [c_cw-1:0] r_cnt;
    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_quo;
    logic [W-1:0]    r_dvs;

    logic [SZ-1:0]   w_sm1;
    logic [SZ-1:0]   w_sm2;
    logic [c_aw-1:0] w_ia;
    logic [c_aw-1:0] w_ib;
    logic [c_aw-1:0] w_ip;
    logic            w_has1;
    logic            w_has2;
    logic            w_full;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic [1:0]      w_chk;
    logic [W:0]      w_shift;
    logic [W:0]      w_sub;
    logic            w_ge;
    logic [W-1:0]    w_rem_nx;
    logic [W-1:0]    w_quo_nx;

    // Entry indices of a (top), b (below top) and the next free slot.
    assign w_sm1  = r_size - SZ'(1);
    assign w_sm2  = r_size - SZ'(2);
    assign w_ia   = w_sm1[c_aw-1:0];
    assign w_ib   = w_sm2[c_aw-1:0];
    assign w_ip   = r_size[c_aw-1:0];
    assign w_has1 = (r_size != '0);
    assign w_has2 = (r_size >= SZ'(2));
    assign w_full = (r_size == SZ'(D));
    assign w_a    = w_has1 ? r_stk[w_ia] : '0;
    assign w_b    = w_has2 ? r_stk[w_ib] : '0;

    assign head  = w_a;
    assign size  = r_size;
    assign empty = ~w_has1;
    assign full  = w_full;
    assign busy  = r_busy;
    assign err   = r_err;
    assign valid = (r_err == 2'd0);

    // Restoring divider step: the dividend is shifted MSB-first out of r_quo
    // into the partial remainder while quotient bits shift in at the bottom.
    assign w_shift  = {r_rem, r_quo[W-1]};
    assign w_ge     = (w_shift >= {1'b0, r_dvs});
    assign w_sub    = w_shift - {1'b0, r_dvs};
    assign w_rem_nx = w_ge ? w_sub[W-1:0] : w_shift[W-1:0];
    assign w_quo_nx = {r_quo[W-2:0], w_ge};

    // Status an accepted op would produce; underflow takes precedence.
    always_comb begin
        w_chk = 2'd0;
        case (op)
            c_op_push:                    if (w_full)  w_chk = 2'd2;
            c_op_pop, c_op_inc, c_op_dec: if (!w_has1) w_chk = 2'd1;
            c_op_add, c_op_sub, c_op_mul,
            c_op_swap:                    if (!w_has2) w_chk = 2'd1;
            c_op_div, c_op_mod: begin
                if (!w_has2)           w_chk = 2'd1;
                else if (w_a == '0)    w_chk = 2'd3;
            end
            c_op_dup: begin
                if (!w_has1)           w_chk = 2'd1;
                else if (w_full)       w_chk = 2'd2;
            end
            c_op_clear:                   w_chk = 2'd0;
            default:                      w_chk = 2'd3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) r_stk[i] <= '0;
            r_size <= '0;
            r_err  <= 2'd0;
            r_busy <= 1'b0;
            r_mod  <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
        end else if (r_busy) begin
            // Operands remain on the stack; the result overwrites b at the
            // final iteration and a is popped in the same edge.
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + c_cw'(1);
            if (r_cnt == c_last) begin
                r_stk[w_ib] <= r_mod ? w_rem_nx : w_quo_nx;
                r_size      <= w_sm1;
                r_busy      <= 1'b0;
            end
        end else if (apply) begin
            r_err <= w_chk;
            if (w_chk == 2'd0) begin
                case (op)
                    c_op_push: begin
                        r_stk[w_ip] <= in;
                        r_size      <= r_size + SZ'(1);
                    end
                    c_op_pop:  r_size <= w_sm1;
                    c_op_inc:  r_stk[w_ia] <= w_a + W'(1);
                    c_op_dec:  r_stk[w_ia] <= w_a - W'(1);
                    c_op_add: begin
                        r_stk[w_ib] <= w_b + w_a;
                        r_size      <= w_sm1;
                    end
                    c_op_sub: begin
                        r_stk[w_ib] <= w_b - w_a;
                        r_size      <= w_sm1;
                    end
                    c_op_mul: begin
                        r_stk[w_ib] <= w_b * w_a;
                        r_size      <= w_sm1;
                    end
                    c_op_div, c_op_mod: begin
                        r_busy <= 1'b1;
                        r_mod  <= (op == c_op_mod);
                        r_cnt  <= '0;
                        r_rem  <= '0;
                        r_quo  <= w_b;
                        r_dvs  <= w_a;
                    end
                    c_op_dup: begin
                        r_stk[w_ip] <= w_a;
                        r_size      <= r_size + SZ'(1);
                    end
                    c_op_swap: begin
                        r_stk[w_ia] <= w_b;
                        r_stk[w_ib] <= w_a;
                    end
                    c_op_clear: r_size <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
